// File: rtl/diff_sample_pacer_if.sv
// Bit-stream in / carrier-sample strobes out bundle for diff_sample_pacer.
// The pacer is the slave; the bit source and sample consumer side is the master.
interface diff_sample_pacer_if #(
    parameter int SAMPLES_PER_CARRIER = 8
);
    localparam int PW = (SAMPLES_PER_CARRIER > 1) ?
        $clog2(SAMPLES_PER_CARRIER) : 1;

    logic          diff_mod_valid;
    logic          diff_mod_data;
    logic          mod_valid;
    logic          mod_bit;
    logic [PW-1:0] mod_phase_idx;
    logic          mod_bit_start;
    logic          mod_active;

    modport master (
        output diff_mod_valid,
        output diff_mod_data,
        input  mod_valid,
        input  mod_bit,
        input  mod_phase_idx,
        input  mod_bit_start,
        input  mod_active
    );

    modport slave (
        input  diff_mod_valid,
        input  diff_mod_data,
        output mod_valid,
        output mod_bit,
        output mod_phase_idx,
        output mod_bit_start,
        output mod_active
    );
endinterface

// File: rtl/diff_sample_pacer.sv
// Buffers diff-encoded bits and paces them out as carrier-sample strobes.
// Define PACER_STATUS_EN to add the ovf_sticky and fill_level status ports.
module diff_sample_pacer #(
    parameter int FIFO_DEPTH          = 64,
    parameter int START_LEVEL         = 32,
    parameter int SAMPLE_DIV          = 50,
    parameter int SAMPLES_PER_BIT     = 40,
    parameter int SAMPLES_PER_CARRIER = 8
) (
    input logic                sys_clk,
    input logic                rst_n,
    diff_sample_pacer_if.slave bus
`ifdef PACER_STATUS_EN
    ,
    output logic                          ovf_sticky,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int SW = (SAMPLES_PER_BIT > 1) ?
        $clog2(SAMPLES_PER_BIT) : 1;
    localparam int PW = (SAMPLES_PER_CARRIER > 1) ?
        $clog2(SAMPLES_PER_CARRIER) : 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] START_CNT = CW'(START_LEVEL);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE   = DW'(SAMPLE_DIV - 2);
    localparam logic [SW-1:0] SMP_LAST  = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(SAMPLES_PER_CARRIER - 1);
    localparam logic [4:0]    GAP_MAX   = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    gap;
    logic [DW-1:0] div;
    logic [SW-1:0] smp;
    logic [PW-1:0] phase;
    logic          mv;
    logic          mb;
    logic          mbs;
    logic          ma;

    logic full;
    logic empty;
    logic wr_en;
    logic pop;
    logic flush;
    logic div_wrap;
    logic bit_end;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wr_en    = bus.diff_mod_valid & ~full;
    assign flush    = ~empty & (gap == GAP_MAX);
    assign div_wrap = (state == PLAY) & (div == DIV_LAST);
    assign bit_end  = div_wrap & (smp == SMP_LAST);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (count >= START_CNT || flush) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = PLAY;
            PLAY: begin
                if (bit_end) begin
                    if (!empty) pop = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= bus.diff_mod_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            gap    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (!wr_en && pop) count <= count - CW'(1);
            if (wr_en)               gap <= '0;
            else if (gap != GAP_MAX) gap <= gap + 5'd1;
        end
    end

    // Strobes are registered one cycle ahead so they line up with div wrap.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            smp   <= '0;
            phase <= '0;
            mv    <= 1'b0;
            mb    <= 1'b0;
            mbs   <= 1'b0;
            ma    <= 1'b0;
        end else begin
            mv  <= (state == PLAY) & (div == DIV_PRE);
            mbs <= (state == PLAY) & (div == DIV_PRE) & (smp == '0);
            if (pop) mb <= mem[rd_ptr];
            if (state == LOAD) begin
                div   <= '0;
                smp   <= '0;
                phase <= '0;
                ma    <= 1'b1;
            end
            if (state == PLAY) begin
                div <= div_wrap ? '0 : div + DW'(1);
                if (div_wrap) begin
                    smp   <= (smp == SMP_LAST) ? '0 : smp + SW'(1);
                    phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
                end
                if (bit_end && empty) ma <= 1'b0;
            end
        end
    end

    assign bus.mod_valid     = mv;
    assign bus.mod_bit       = mb;
    assign bus.mod_phase_idx = phase;
    assign bus.mod_bit_start = mbs;
    assign bus.mod_active    = ma;

`ifdef PACER_STATUS_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                      ovf_sticky <= 1'b0;
        else if (bus.diff_mod_valid && full) ovf_sticky <= 1'b1;
    end

    assign fill_level = count;
`endif
endmodule

// File: tb/tb_diff_sample_pacer.sv
// Directed bench for diff_sample_pacer: burst, phase, flush, overflow,
// streaming and reset scenarios with hand-derived expectations.
module tb_diff_sample_pacer;
    localparam int FD  = 16;
    localparam int SL  = 8;
    localparam int SD  = 4;
    localparam int SPB = 8;
    localparam int SPC = 4;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;

    diff_sample_pacer_if #(.SAMPLES_PER_CARRIER(SPC)) bus();

`ifdef PACER_STATUS_EN
    logic       ovf_sticky;
    logic [4:0] fill_level;
`endif

    diff_sample_pacer #(
        .FIFO_DEPTH(FD),
        .START_LEVEL(SL),
        .SAMPLE_DIV(SD),
        .SAMPLES_PER_BIT(SPB),
        .SAMPLES_PER_CARRIER(SPC)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef PACER_STATUS_EN
        ,
        .ovf_sticky(ovf_sticky),
        .fill_level(fill_level)
`endif
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic       b;
        logic [1:0] ph;
        logic       st;
        int         c;
    } smp_t;

    smp_t q[$];
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   rise_cnt = 0;
    logic prev_act = 1'b0;

    always @(negedge sys_clk) begin
        if (bus.mod_valid === 1'b1)
            q.push_back('{bus.mod_bit, bus.mod_phase_idx,
                          bus.mod_bit_start, cyc});
        if (bus.mod_active === 1'b1 && prev_act !== 1'b1) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        if (bus.mod_active !== 1'b1 && prev_act === 1'b1)
            fall_cyc = cyc;
        prev_act = bus.mod_active;
    end

    task automatic send(input logic bits[$], output int last_cyc);
        foreach (bits[i]) begin
            @(posedge sys_clk); #1;
            bus.diff_mod_valid = 1'b1;
            bus.diff_mod_data  = bits[i];
        end
        @(posedge sys_clk); #1;
        bus.diff_mod_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic wait_frame(input int budget, input string tag);
        int n = 0;
        while (bus.mod_active !== 1'b1 && n < budget) begin
            @(negedge sys_clk); #1; n++;
        end
        while (bus.mod_active === 1'b1 && n < budget) begin
            @(negedge sys_clk); #1; n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: waited %0d cycles, limit %0d",
                     tag, n, budget);
        end
    endtask

    task automatic test_reset;
        int n0;
        bus.diff_mod_valid = 1'b0;
        bus.diff_mod_data  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({bus.mod_valid, bus.mod_bit, bus.mod_phase_idx,
             bus.mod_bit_start, bus.mod_active} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.mod_valid, bus.mod_bit, bus.mod_phase_idx,
                      bus.mod_bit_start, bus.mod_active});
        end
`ifdef PACER_STATUS_EN
        checks++;
        if ({ovf_sticky, fill_level} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 000000",
                     {ovf_sticky, fill_level});
        end
`endif
        rst_n = 1'b1;
        n0 = q.size();
        repeat (30) @(posedge sys_clk);
        #1;
        checks++;
        if (q.size() !== n0 || bus.mod_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: strobes %0d active %b expected 0 0",
                     q.size() - n0, bus.mod_active);
        end
    endtask

    task automatic test_burst;
        logic bits[$] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int c0;
        q.delete();
        rise_cnt = 0;
        send(bits, c0);
        wait_frame(400, "burst");
        checks++;
        if (rise_cyc - c0 !== 2) begin
            errors++;
            $display("FAIL burst_start: got %0d expected 2", rise_cyc - c0);
        end
        checks++;
        if (q.size() !== 64) begin
            errors++;
            $display("FAIL burst_count: got %0d expected 64", q.size());
        end
        for (int i = 0; i < q.size() && i < 64; i++) begin
            checks++;
            if (q[i].b !== bits[i / SPB]) begin
                errors++;
                $display("FAIL burst_bit[%0d]: got %b expected %b",
                         i, q[i].b, bits[i / SPB]);
            end
            checks++;
            if (q[i].st !== (i % SPB == 0)) begin
                errors++;
                $display("FAIL burst_bit_start[%0d]: got %b expected %b",
                         i, q[i].st, (i % SPB == 0));
            end
            checks++;
            if (i == 0 ? (q[0].c - rise_cyc !== SD - 1)
                       : (q[i].c - q[i-1].c !== SD)) begin
                errors++;
                $display("FAIL burst_spacing[%0d]: got %0d", i,
                         i == 0 ? q[0].c - rise_cyc : q[i].c - q[i-1].c);
            end
        end
    endtask

    task automatic test_phase;
        for (int i = 0; i < q.size() && i < 64; i++) begin
            checks++;
            if (q[i].ph !== 2'(i % SPC)) begin
                errors++;
                $display("FAIL phase_idx[%0d]: got %0d expected %0d",
                         i, q[i].ph, i % SPC);
            end
        end
        checks++;
        if (q.size() < 64 || fall_cyc - q[63].c !== 1) begin
            errors++;
            $display("FAIL phase_active_clear: got %0d expected 1",
                     q.size() < 64 ? -1 : fall_cyc - q[63].c);
        end
    endtask

    task automatic test_flush;
        logic bits[$] = '{1'b1, 1'b1, 1'b0};
        int c0;
        q.delete();
        send(bits, c0);
        wait_frame(300, "flush");
        checks++;
        if (rise_cyc - c0 !== 18) begin
            errors++;
            $display("FAIL flush_start: got %0d expected 18", rise_cyc - c0);
        end
        checks++;
        if (q.size() !== 24) begin
            errors++;
            $display("FAIL flush_count: got %0d expected 24", q.size());
        end
        for (int i = 0; i < q.size() && i < 24; i++) begin
            checks++;
            if (q[i].b !== bits[i / SPB]) begin
                errors++;
                $display("FAIL flush_bit[%0d]: got %b expected %b",
                         i, q[i].b, bits[i / SPB]);
            end
        end
    endtask

    task automatic test_overflow;
        logic one[$] = '{1'b1};
        logic bits[$] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1,
                          1, 1, 1, 1};
        logic exp_b;
        int c0;
        int n = 0;
        q.delete();
        send(one, c0);
        while (q.size() < 1 && n < 200) begin
            @(negedge sys_clk); #1; n++;
        end
        checks++;
        if (q.size() < 1) begin
            errors++;
            $display("FAIL ovf_first_strobe: got none expected 1");
        end
        send(bits, c0);
`ifdef PACER_STATUS_EN
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf_sticky);
        end
        checks++;
        if (fill_level !== 5'd16) begin
            errors++;
            $display("FAIL ovf_fill_level: got %0d expected 16", fill_level);
        end
`endif
        wait_frame(800, "ovf");
        checks++;
        if (q.size() !== 17 * SPB) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected %0d",
                     q.size(), 17 * SPB);
        end
        for (int i = 0; i < q.size() && i < 17 * SPB; i += SPB) begin
            exp_b = (i == 0) ? 1'b1 : bits[i / SPB - 1];
            checks++;
            if (q[i].b !== exp_b) begin
                errors++;
                $display("FAIL ovf_bit[%0d]: got %b expected %b",
                         i, q[i].b, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic a[$] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic b[$] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic all[$];
        int c0;
        int n = 0;
        all = {a, b};
        q.delete();
        rise_cnt = 0;
        send(a, c0);
        while (q.size() < 20 && n < 300) begin
            @(negedge sys_clk); #1; n++;
        end
        send(b, c0);
        wait_frame(800, "stream");
        checks++;
        if (q.size() !== 128 || rise_cnt !== 1) begin
            errors++;
            $display("FAIL stream_count: got %0d/%0d expected 128/1",
                     q.size(), rise_cnt);
        end
        for (int i = 0; i < q.size() && i < 128; i++) begin
            checks++;
            if (q[i].b !== all[i / SPB] || q[i].ph !== 2'(i % SPC) ||
                (i > 0 && q[i].c - q[i-1].c !== SD)) begin
                errors++;
                $display("FAIL stream_sample[%0d]: bit %b ph %0d expected %b %0d",
                         i, q[i].b, q[i].ph, all[i / SPB], i % SPC);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic bits[$] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic one[$] = '{1'b1};
        int c0;
        int n = 0;
        q.delete();
        send(bits, c0);
        while (q.size() < 21 && n < 300) begin
            @(negedge sys_clk); #1; n++;
        end
        checks++;
        if (bus.mod_valid !== 1'b1 || bus.mod_bit !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid %b bit %b expected 1 1",
                     bus.mod_valid, bus.mod_bit);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mod_valid, bus.mod_bit, bus.mod_phase_idx,
             bus.mod_bit_start, bus.mod_active} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b expected 000000",
                     {bus.mod_valid, bus.mod_bit, bus.mod_phase_idx,
                      bus.mod_bit_start, bus.mod_active});
        end
`ifdef PACER_STATUS_EN
        checks++;
        if (fill_level !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_fill: got %0d expected 0", fill_level);
        end
`endif
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        q.delete();
        rise_cnt = 0;
        repeat (40) @(posedge sys_clk);
        #1;
        checks++;
        if (q.size() !== 0 || rise_cnt !== 0) begin
            errors++;
            $display("FAIL rst_fifo_empty: strobes %0d starts %0d expected 0 0",
                     q.size(), rise_cnt);
        end
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        send(one, c0);
        wait_frame(300, "rst_first");
        checks++;
        if (q.size() !== SPB || rise_cyc - c0 !== 18) begin
            errors++;
            $display("FAIL rst_first_write: strobes %0d start %0d expected 8 18",
                     q.size(), rise_cyc - c0);
        end
        checks++;
        if (q.size() < 1 || q[0].b !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_bit: got %b expected 1",
                     q.size() < 1 ? 1'bx : q[0].b);
        end
    endtask

    initial begin
        bus.diff_mod_valid = 1'b0;
        bus.diff_mod_data  = 1'b0;
        test_reset();
        test_burst();
        test_phase();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/diff_sample_pacer.md
DIFF_SAMPLE_PACER -- requirements
Module: diff_sample_pacer

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 64, giving the bit FIFO depth; it SHALL be a power of two of at least 4.
REQ-002 The block SHALL have the parameter START_LEVEL, default 32, giving the FIFO fill (in bits) that starts playback; it SHALL be between 1 and FIFO_DEPTH.
REQ-003 The block SHALL have the parameter SAMPLE_DIV, default 50, giving the sys_clk cycles per output sample (fs tick); it SHALL be at least 2.
REQ-004 The block SHALL have the parameter SAMPLES_PER_BIT, default 40, giving samples per diff bit (fs/fb).
REQ-005 The block SHALL have the parameter SAMPLES_PER_CARRIER, default 8, giving samples per carrier period (fs/fc); SAMPLES_PER_BIT SHALL be an integer multiple of it.
REQ-006 The block SHALL have a port sys_clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have a port diff_mod_valid, input, 1 bit: write strobe for a differentially encoded bit, possibly asserted on every cycle.
REQ-009 The block SHALL have a port diff_mod_data, input, 1 bit: the differentially encoded bit.
REQ-010 The block SHALL have a port mod_valid, output, 1 bit: one-cycle strobe per output sample.
REQ-011 The block SHALL have a port mod_bit, output, 1 bit: the current bit, which selects carrier phase 0 or pi.
REQ-012 The block SHALL have a port mod_phase_idx, output, clog2(SAMPLES_PER_CARRIER) bits: the carrier sample index.
REQ-013 The block SHALL have a port mod_bit_start, output, 1 bit: high with mod_valid on the first sample of each bit.
REQ-014 The block SHALL have a port mod_active, output, 1 bit: high while a frame is playing.

Function
REQ-015 The block SHALL store bits in a FIFO of FIFO_DEPTH entries with a fill count of clog2(FIFO_DEPTH)+1 bits.
REQ-016 A write SHALL occur on diff_mod_valid when the FIFO is not full; when full, the bit SHALL be dropped and the FIFO contents SHALL be unchanged.
REQ-017 On a simultaneous write and pop, the fill count SHALL be unchanged and both operations SHALL take effect.
REQ-018 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The state machine SHALL have the states IDLE, LOAD and PLAY.
REQ-020 In IDLE, when the fill count is at least START_LEVEL, the block SHALL pop the head bit into mod_bit and enter LOAD.
REQ-021 In IDLE, when the fill count is nonzero and there has been no write for 16 consecutive cycles, the block SHALL likewise pop the head bit and enter LOAD (short-frame flush).
REQ-022 LOAD SHALL last one cycle: the sample divider, sample counter and phase counter SHALL be cleared to 0 and mod_active set to 1, then the block SHALL enter PLAY.
REQ-023 In PLAY, the divider SHALL count 0 to SAMPLE_DIV-1; at SAMPLE_DIV-1 it SHALL wrap and mod_valid SHALL pulse high for one cycle.
REQ-024 The first mod_valid SHALL therefore occur SAMPLE_DIV cycles after the LOAD cycle.
REQ-025 At each mod_valid, mod_phase_idx SHALL present the phase counter, which then advances modulo SAMPLES_PER_CARRIER.
REQ-026 At each mod_valid, the sample counter SHALL advance modulo SAMPLES_PER_BIT.
REQ-027 mod_bit_start SHALL equal (sample counter == 0) & mod_valid.
REQ-028 At the mod_valid of sample SAMPLES_PER_BIT-1, when the FIFO is non-empty, the next bit SHALL be popped into mod_bit, with no gap between bits.
REQ-029 The phase counter SHALL continue across bit boundaries and SHALL NOT be reset per bit.
REQ-030 At the mod_valid of sample SAMPLES_PER_BIT-1, when the FIFO is empty, the block SHALL return to IDLE and clear mod_active in the following cycle.
REQ-031 mod_bit SHALL hold its last value while idle.
REQ-032 The outputs mod_bit, mod_valid, mod_bit_start and mod_active SHALL be registered.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously clear the FIFO pointers, fill count, divider, counters and idle-gap counter, and set the state to IDLE.
REQ-034 Asserting rst_n low SHALL force mod_valid=0, mod_bit=0, mod_phase_idx=0, mod_bit_start=0 and mod_active=0.
REQ-035 Reset asserted in mid-frame SHALL discard all buffered bits.
REQ-036 A diff_mod_valid pulse in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-037 With PACER_STATUS_EN defined, the block SHALL add the output ports ovf_sticky (1 bit) and fill_level (clog2(FIFO_DEPTH)+1 bits).
REQ-038 ovf_sticky SHALL be set by a write attempted while the FIFO is full and SHALL be cleared only by reset.
REQ-039 fill_level SHALL be the registered fill count.
REQ-040 With PACER_STATUS_EN undefined, those ports and their logic SHALL be absent and the remaining behaviour SHALL be identical.

Verification (bench parameters: FIFO_DEPTH=16, START_LEVEL=8, SAMPLE_DIV=4, SAMPLES_PER_BIT=8, SAMPLES_PER_CARRIER=4)
REQ-041 Burst test: a back-to-back burst of 8 bits 1,0,1,1,0,0,1,0 SHALL produce 64 mod_valid strobes spaced 4 cycles apart, mod_bit following the sequence with 8 samples per bit, and mod_bit_start high on strobes 0, 8, ..., 56.
REQ-042 Phase test: over the 64 strobes of the burst test, mod_phase_idx SHALL cycle 0,1,2,3 continuously across bit boundaries, and mod_active SHALL clear one cycle after strobe 63.
REQ-043 Flush test: 3 bits followed by silence SHALL leave the block in IDLE for 16 cycles, then produce 24 strobes.
REQ-044 Overflow test: 20 back-to-back bits SHALL keep the first 16; the last 4 SHALL be dropped, and with PACER_STATUS_EN ovf_sticky SHALL be 1 and fill_level SHALL read 16 before the first pop.
REQ-045 Streaming test: a new 8-bit burst written during PLAY SHALL be appended seamlessly, with no idle gap between bits.
REQ-046 Reset test: rst_n low at strobe 20 SHALL drive all outputs to 0 within the same cycle, and after release the FIFO SHALL be empty.
